rca_nibble_sequencer: RTL and testbench

Multi-cycle controller that performs WIDTH-bit add/subtract by time-sharing one external 4-bit ripple-carry adder (rca_4_bit), one nibble per clock, LSB nibble first. It latches operands on a start request and drives the adder slice each cycle. It registers each 4-bit sum and the inter-nibble carry, then reports result, carry-out and signed overflow with a done pulse. It sits between a requesting datapath and the shared adder slice; the parent wires the add_* ports to the adder's scalar bit ports.

---
 rtl/rca_nibble_sequencer.sv | 135 +++++++++++++
 tb/tb_rca_nibble_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_nibble_sequencer.sv
// Nibble-serial add/subtract controller. Time-shares one external 4-bit
// ripple-carry adder: one nibble per clock, LSB nibble first, with the
// inter-nibble carry held in a register between cycles.
module rca_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [3:0]       add_s,
    input  logic             add_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] beff_reg;
    logic             carry_reg;
    logic [IDXW-1:0]  idx_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             ovf_reg;

    // Per-nibble views of the latched operands, selected by idx_reg below.
    logic [3:0] a_nib [NIB];
    logic [3:0] b_nib [NIB];

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = beff_reg[4*gi +: 4];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a start is only honoured from IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (idx_reg == LAST_IDX) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: adder slice is driven only in RUN, otherwise held at zero.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        add_a  = 4'd0;
        add_b  = 4'd0;
        add_ci = 1'b0;
        case (state_reg)
            ST_RUN: begin
                busy   = 1'b1;
                add_a  = a_nib[idx_reg];
                add_b  = b_nib[idx_reg];
                add_ci = carry_reg;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch operands on start, collect one sum nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            beff_reg   <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        // Subtraction is A + ~B + 1, so invert B and force carry-in.
                        beff_reg  <= sub ? ~op_b : op_b;
                        carry_reg <= sub ? 1'b1 : cin_in;
                        idx_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    result_reg[{idx_reg, 2'b00} +: 4] <= add_s;
                    carry_reg <= add_co;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg <= add_co;
                        ovf_reg  <= (a_reg[WIDTH-1] == beff_reg[WIDTH-1]) &&
                                    (add_s[3] != a_reg[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
    assign cout   = cout_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Directed bench for rca_nibble_sequencer with a behavioural 4-bit adder.
module tb_rca_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin_in;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_ci;
    logic [3:0]  add_s;
    logic        add_co;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int fails  = 0;

    // Per-cycle observations of the most recent operation (cycle k follows edge k).
    int          busy_cnt;
    int          done_cnt;
    int          done_cyc;
    logic        ci_hist   [8];
    logic        busy_hist [8];
    logic        done_hist [8];
    logic [3:0]  a_hist    [8];
    logic [15:0] res_hist  [8];
    logic [15:0] res_done;
    logic        cout_done;
    logic        ovf_done;

    always #5 clk = ~clk;

    // Behavioural 4-bit ripple-carry adder slice.
    logic [4:0] slice_sum;
    assign slice_sum = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};
    assign add_s  = slice_sum[3:0];
    assign add_co = slice_sum[4];

    rca_nibble_sequencer #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .cin_in (cin_in),
        .op_a   (op_a),
        .op_b   (op_b),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    // Issues one start and records eight cycles of outputs. restart_mask bit k
    // re-asserts start (with different operands) while cycle k's state is
    // sampled; rst_cyc likewise asserts rst for that one cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic ci,
                          input logic [7:0] restart_mask, input int rst_cyc);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; cin_in = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = ~a; op_b = ~b; sub = ~s;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        res_done = 16'hxxxx; cout_done = 1'bx; ovf_done = 1'bx;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ci_hist[k]   = add_ci;
            busy_hist[k] = busy;
            done_hist[k] = done;
            a_hist[k]    = add_a;
            res_hist[k]  = result;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc  = k;
                    res_done  = result;
                    cout_done = cout;
                    ovf_done  = ovf;
                end
            end
            if (restart_mask[k]) begin
                start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b0; cin_in = 1'b0;
            end else begin
                start = 1'b0;
            end
            rst = (rst_cyc == k);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin_in = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, cout, ovf} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags: got busy/done/cout/ovf=%b want 0000", {busy, done, cout, ovf});
        end
        checks++;
        if (result !== 16'h0000) begin
            fails++; $display("FAIL reset_result: got %h want 0000", result);
        end
        checks++;
        if ({add_a, add_b, add_ci} !== 9'd0) begin
            fails++; $display("FAIL reset_adder_port: got a=%h b=%h ci=%b want 0", add_a, add_b, add_ci);
        end
        rst = 1'b0;
        $display("reset: busy=%b done=%b result=%h", busy, done, result);
    endtask

    task automatic test_basic_add;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 8'h00, -1);
        $display("add 1234+4321: result=%h cout=%b ovf=%b done_cyc=%0d busy_cnt=%0d",
                 res_done, cout_done, ovf_done, done_cyc, busy_cnt);
        checks++;
        if (res_done !== 16'h5555 || cout_done !== 1'b0 || ovf_done !== 1'b0) begin
            fails++; $display("FAIL basic_add: got %h/%b/%b want 5555/0/0", res_done, cout_done, ovf_done);
        end
        checks++;
        if (busy_cnt != 4 || busy_hist[0] !== 1'b1 || busy_hist[3] !== 1'b1) begin
            fails++; $display("FAIL basic_busy: got %0d busy cycles want 4 in cycles 0..3", busy_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 4) begin
            fails++; $display("FAIL basic_done: got %0d pulses at cycle %0d want 1 at cycle 4", done_cnt, done_cyc);
        end
        checks++;
        if (a_hist[0] !== 4'h4 || a_hist[3] !== 4'h1 || a_hist[5] !== 4'h0) begin
            fails++; $display("FAIL basic_add_a: got %h,%h,%h want 4,1,0", a_hist[0], a_hist[3], a_hist[5]);
        end
        checks++;
        if (result !== 16'h5555) begin
            fails++; $display("FAIL basic_hold: got %h want 5555", result);
        end
    endtask

    task automatic test_carry_ripple;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 8'h00, -1);
        $display("add FFFF+0001: result=%h cout=%b ovf=%b ci=%b%b%b%b",
                 res_done, cout_done, ovf_done, ci_hist[0], ci_hist[1], ci_hist[2], ci_hist[3]);
        checks++;
        if (res_done !== 16'h0000 || cout_done !== 1'b1 || ovf_done !== 1'b0) begin
            fails++; $display("FAIL carry_ripple: got %h/%b/%b want 0000/1/0", res_done, cout_done, ovf_done);
        end
        checks++;
        if ({ci_hist[0], ci_hist[1], ci_hist[2], ci_hist[3]} !== 4'b0111) begin
            fails++; $display("FAIL carry_ci: got %b%b%b%b want 0111",
                              ci_hist[0], ci_hist[1], ci_hist[2], ci_hist[3]);
        end
    endtask

    task automatic test_subtract;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 8'h00, -1);
        $display("sub 0005-0007: result=%h cout=%b ovf=%b", res_done, cout_done, ovf_done);
        checks++;
        if (res_done !== 16'hFFFE || cout_done !== 1'b0 || ovf_done !== 1'b0) begin
            fails++; $display("FAIL sub_borrow: got %h/%b/%b want FFFE/0/0", res_done, cout_done, ovf_done);
        end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 8'h00, -1);
        $display("sub 8000-0001: result=%h cout=%b ovf=%b", res_done, cout_done, ovf_done);
        checks++;
        if (res_done !== 16'h7FFF || cout_done !== 1'b1 || ovf_done !== 1'b1) begin
            fails++; $display("FAIL sub_ovf: got %h/%b/%b want 7FFF/1/1", res_done, cout_done, ovf_done);
        end
    endtask

    task automatic test_overflow_and_cin;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 8'h00, -1);
        $display("add 7FFF+0001: result=%h cout=%b ovf=%b", res_done, cout_done, ovf_done);
        checks++;
        if (res_done !== 16'h8000 || cout_done !== 1'b0 || ovf_done !== 1'b1) begin
            fails++; $display("FAIL add_ovf: got %h/%b/%b want 8000/0/1", res_done, cout_done, ovf_done);
        end
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 8'h00, -1);
        $display("add 0000+0000+cin: result=%h cout=%b ovf=%b", res_done, cout_done, ovf_done);
        checks++;
        if (res_done !== 16'h0001 || cout_done !== 1'b0 || ovf_done !== 1'b0) begin
            fails++; $display("FAIL add_cin: got %h/%b/%b want 0001/0/0", res_done, cout_done, ovf_done);
        end
    endtask

    task automatic test_busy_protection;
        // Re-pulse start during RUN (cycle 1) and in DONE (cycle 4).
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 8'b0001_0010, -1);
        $display("protect 1111+2222: result=%h done_cnt=%0d busy_cnt=%0d", res_done, done_cnt, busy_cnt);
        checks++;
        if (res_done !== 16'h3333 || cout_done !== 1'b0) begin
            fails++; $display("FAIL protect_result: got %h/%b want 3333/0", res_done, cout_done);
        end
        checks++;
        if (done_cnt != 1 || busy_cnt != 4 || busy_hist[5] !== 1'b0) begin
            fails++; $display("FAIL protect_single: got done=%0d busy=%0d want 1 and 4", done_cnt, busy_cnt);
        end
        checks++;
        if (res_hist[7] !== 16'h3333) begin
            fails++; $display("FAIL protect_hold: got %h want 3333", res_hist[7]);
        end
    endtask

    task automatic test_reset_mid_op;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 8'h00, 2);
        $display("reset mid-op: busy=%b result=%h done_cnt=%0d", busy_hist[3], res_hist[3], done_cnt);
        checks++;
        if (busy_hist[3] !== 1'b0 || res_hist[3] !== 16'h0000) begin
            fails++; $display("FAIL midrst_abort: got busy=%b result=%h want 0/0000", busy_hist[3], res_hist[3]);
        end
        checks++;
        if (done_cnt != 0) begin
            fails++; $display("FAIL midrst_nodone: got %0d done pulses want 0", done_cnt);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 8'h00, -1);
        $display("add 00FF+0001 after reset: result=%h cout=%b ovf=%b", res_done, cout_done, ovf_done);
        checks++;
        if (res_done !== 16'h0100 || cout_done !== 1'b0 || ovf_done !== 1'b0 || done_cyc != 4) begin
            fails++; $display("FAIL midrst_recover: got %h/%b/%b cyc %0d want 0100/0/0 cyc 4",
                              res_done, cout_done, ovf_done, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_subtract();
        test_overflow_and_cin();
        test_busy_protection();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
